// File: rtl/hamming_secded_encoder_if.sv
// Stream interface for hamming_secded_encoder: input word handshake,
// output codeword handshake and the emitted-word counter.
// Build option: HAMMING_ENC_SECDED_EN adds the overall-parity bit to code_out.
interface hamming_secded_encoder_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
);
  // Smallest P with 2**P >= DATA_W+P+1
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((1 << p) < (dw + p + 1)) p++;
    return p;
  endfunction

  localparam int P = calc_p(DATA_W);
`ifdef HAMMING_ENC_SECDED_EN
  localparam int CODE_W = DATA_W + P + 1;
`else
  localparam int CODE_W = DATA_W + P;
`endif

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] code_out;
  logic [CNT_W-1:0]  words_out;

  // Encoder side
  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, code_out, words_out
  );

  // Word source / codeword sink side
  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, code_out, words_out
  );
endinterface

// File: rtl/hamming_secded_encoder.sv
// Parametrised Hamming encoder with a 2-entry skid buffer on a valid/ready
// stream. Parity p_j sits at position 2**j; data bits fill the remaining
// positions in ascending order (position k maps to code_out[k-1]).
// Build option: HAMMING_ENC_SECDED_EN appends an even overall-parity bit.
module hamming_secded_encoder #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  hamming_secded_encoder_if.slave   bus
);
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((1 << p) < (dw + p + 1)) p++;
    return p;
  endfunction

  localparam int P      = calc_p(DATA_W);
  localparam int BASE_W = DATA_W + P;
`ifdef HAMMING_ENC_SECDED_EN
  localparam int CODE_W = BASE_W + 1;
`else
  localparam int CODE_W = BASE_W;
`endif

  if (DATA_W < 1 || DATA_W > 57) begin : g_bad_width
    $error("hamming_secded_encoder: DATA_W must be in 1..57");
  end

  // Index of the data bit that lands on 1-based position k
  function automatic int data_idx(input int k);
    int n;
    n = 0;
    for (int q = 1; q < k; q++)
      if ((q & (q - 1)) != 0) n++;
    return n;
  endfunction

  // Positions covered by parity bit at power-of-two position k
  function automatic logic [BASE_W-1:0] pmask(input int k);
    logic [BASE_W-1:0] m;
    m = '0;
    for (int p = 1; p <= BASE_W; p++)
      if ((p & k) != 0) m = m | (BASE_W'(1) << (p - 1));
    return m;
  endfunction

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] r_skid;
  logic [CNT_W-1:0]  r_cnt;

  logic [BASE_W-1:0] w_spread;
  logic [BASE_W-1:0] w_par;
  logic [BASE_W-1:0] w_base;
  logic [CODE_W-1:0] w_enc;
  logic              w_in_xfer;
  logic              w_out_xfer;

  // Spread data over non-power-of-two positions, parity over the powers of two
  for (genvar k = 1; k <= BASE_W; k++) begin : g_pos
    if ((k & (k - 1)) == 0) begin : g_par
      assign w_spread[k-1] = 1'b0;
      assign w_par[k-1]    = ^(w_spread & pmask(k));
    end else begin : g_dat
      assign w_spread[k-1] = bus.data_in[data_idx(k)];
      assign w_par[k-1]    = 1'b0;
    end
  end

  assign w_base = w_spread | w_par;
`ifdef HAMMING_ENC_SECDED_EN
  assign w_enc = {^w_base, w_base};
`else
  assign w_enc = w_base;
`endif

  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & bus.out_ready;

  // Skid-buffer FSM: output register, skid register, ready and word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_code      <= '0;
      r_skid      <= '0;
      r_cnt       <= '0;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready <= 1'b1;
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_code      <= w_enc;
            r_out_valid <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_code <= w_enc;
            r_cnt  <= r_cnt + CNT_W'(1);
          end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_cnt       <= r_cnt + CNT_W'(1);
            r_state     <= S_EMPTY;
          end else if (w_in_xfer) begin
            r_skid     <= w_enc;
            r_in_ready <= 1'b0;
            r_state    <= S_FULL;
          end
        end
        S_FULL: begin
          if (w_out_xfer) begin
            r_code  <= r_skid;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= S_ONE;
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.code_out  = r_code;
  assign bus.words_out = r_cnt;
endmodule

// File: tb/tb_hamming_secded_encoder.sv
// Bench for hamming_secded_encoder: directed checks on a DATA_W=4 / CNT_W=4
// instance and a randomized scoreboard run on a DATA_W=11 instance.
// Honours HAMMING_ENC_SECDED_EN the same way the design does.
module tb_hamming_secded_encoder;
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((1 << p) < (dw + p + 1)) p++;
    return p;
  endfunction

  localparam int DWA = 4;
  localparam int DWB = 11;

  logic clk;
  logic rst_n;
  logic flush_a;
  logic flush_b;
  int   n_tests;
  int   n_fail;

  hamming_secded_encoder_if #(.DATA_W(DWA), .CNT_W(4))  ifa ();
  hamming_secded_encoder_if #(.DATA_W(DWB), .CNT_W(16)) ifb ();

  hamming_secded_encoder #(.DATA_W(DWA), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(ifa.slave)
  );
  hamming_secded_encoder #(.DATA_W(DWB), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference codeword straight from the position rules
  function automatic logic [63:0] ref_code(input int dw, input logic [63:0] d);
    logic [63:0] c;
    logic        b;
    int          p, n, di;
    p  = calc_p(dw);
    n  = dw + p;
    c  = '0;
    di = 0;
    for (int k = 1; k <= n; k++) begin
      if ((k & (k - 1)) != 0) begin
        c[k-1] = d[di];
        di++;
      end
    end
    for (int j = 0; j < p; j++) begin
      b = 1'b0;
      for (int k = 1; k <= n; k++)
        if (((k >> j) & 1) == 1 && (k & (k - 1)) != 0) b = b ^ c[k-1];
      c[(1 << j) - 1] = b;
    end
`ifdef HAMMING_ENC_SECDED_EN
    c[n] = ^c;
`endif
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [DWA-1:0] w1, w2, w3, last;
  logic [DWB-1:0] db;
  logic [63:0]    q[$];
  int             sent, rcvd, cyc;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    flush_a = 1'b0;
    flush_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.data_in = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.data_in = '0; ifb.out_ready = 1'b0;

    // Reset values and in_ready rising on the first edge after release
    #1;
    check("rst_in_ready",  ifa.in_ready,  0);
    check("rst_out_valid", ifa.out_valid, 0);
    check("rst_code",      ifa.code_out,  0);
    check("rst_words",     ifa.words_out, 0);
    tick();
    rst_n = 1'b1;
    check("rel_in_ready_before_edge", ifa.in_ready, 0);
    tick();
    check("rel_in_ready_after_edge", ifa.in_ready, 1);

    // Known vectors
    ifa.in_valid = 1'b1; ifa.data_in = 4'b1011; ifa.out_ready = 1'b1;
    tick();
    check("v1011_valid", ifa.out_valid, 1);
    check("v1011_code",  ifa.code_out,  64'h55);
    ifa.in_valid = 1'b0;
    tick();
    check("v1011_words", ifa.words_out, 1);
    check("v1011_drain", ifa.out_valid, 0);

    ifa.in_valid = 1'b1; ifa.data_in = 4'b0001;
    tick();
`ifdef HAMMING_ENC_SECDED_EN
    check("v0001_code", ifa.code_out, 64'h87);
`else
    check("v0001_code", ifa.code_out, 64'h07);
`endif
    ifa.data_in = 4'b1011;
    tick();
    check("v1011b_code",  ifa.code_out,  64'h55);
    check("v1011b_words", ifa.words_out, 2);
    ifa.in_valid = 1'b0;
    tick();
    check("v1011b_words_drain", ifa.words_out, 3);

    // Backpressure: two words fill the buffer, a third is refused
    w1 = 4'($urandom); w2 = 4'($urandom); w3 = 4'($urandom);
    ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.data_in = w1;
    tick();
    ifa.data_in = w2;
    tick();
    check("bp_full_ready", ifa.in_ready,  0);
    check("bp_full_valid", ifa.out_valid, 1);
    check("bp_hold_w1",    ifa.code_out,  ref_code(DWA, 64'(w1)));
    ifa.data_in = w3;
    tick();
    check("bp_still_w1",  ifa.code_out, ref_code(DWA, 64'(w1)));
    check("bp_still_full", ifa.in_ready, 0);
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
    tick();
    check("bp_w2",       ifa.code_out,  ref_code(DWA, 64'(w2)));
    check("bp_w2_words", ifa.words_out, 4);
    check("bp_w2_ready", ifa.in_ready,  1);
    tick();
    check("bp_empty",    ifa.out_valid, 0);
    check("bp_words",    ifa.words_out, 5);

    // Counter wrap: 17 transfers on a 4-bit counter
    reset_all();
    ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
    last = '0;
    for (int i = 0; i < 17; i++) begin
      last = 4'($urandom);
      ifa.data_in = last;
      tick();
    end
    ifa.in_valid = 1'b0;
    check("wrap_last_code", ifa.code_out, ref_code(DWA, 64'(last)));
    tick();
    check("wrap_words", ifa.words_out, 1);

    // Flush while FULL discards both transfers and leaves the counter alone
    ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.data_in = 4'($urandom);
    tick();
    ifa.data_in = 4'($urandom);
    tick();
    check("fl_full", ifa.in_ready, 0);
    flush_a = 1'b1; ifa.out_ready = 1'b1;
    tick();
    flush_a = 1'b0; ifa.in_valid = 1'b0;
    check("fl_valid", ifa.out_valid, 0);
    check("fl_ready", ifa.in_ready,  1);
    check("fl_words", ifa.words_out, 1);
    tick();
    check("fl_no_input", ifa.out_valid, 0);
    check("fl_words2",   ifa.words_out, 1);

    // Asynchronous reset while FULL, between edges
    ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.data_in = 4'b1011;
    tick();
    ifa.data_in = 4'b0001;
    tick();
    ifa.in_valid = 1'b0;
    check("ar_full_valid", ifa.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", ifa.out_valid, 0);
    check("ar_code",  ifa.code_out,  0);
    check("ar_ready", ifa.in_ready,  0);
    check("ar_words", ifa.words_out, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_recover_ready", ifa.in_ready, 1);

    // Randomized stream against the scoreboard
    sent = 0; rcvd = 0; cyc = 0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      db = DWB'($urandom);
      ifb.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      ifb.data_in   = db;
      ifb.out_ready = 1'($urandom_range(0, 1));
      if (ifb.in_valid && ifb.in_ready) begin
        q.push_back(ref_code(DWB, 64'(db)));
        sent++;
      end
      if (ifb.out_valid && ifb.out_ready) begin
        if (q.size() == 0) check("stream_extra_word", 1, 0);
        else check("stream_code", 64'(ifb.code_out), q.pop_front());
        rcvd++;
      end
      tick();
      cyc++;
    end
    ifb.in_valid = 1'b0;
    check("stream_budget", (cyc < 20000), 1);
    check("stream_rcvd",   rcvd, 1000);
    check("stream_words",  ifb.words_out, 1000);
    check("stream_idle",   ifb.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
